// File: rtl/sampler_pkg.sv
// Shared types and constants for the constraint sample sequencer.
// SAMPLER_DEDUP_EN (optional) is consumed by constraint_sample_sequencer.
package sampler_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StWait,
        StEmit,
        StDone
    } state_e;

    function automatic int unsigned nwords(input int unsigned vec_w);
        return (vec_w + 31) / 32;
    endfunction

endpackage

// File: rtl/sampler_lfsr32.sv
// 32-bit Galois right-shift LFSR with seed load and zero-seed guard.
// Exposes the next state so the caller can capture it in the same cycle it advances.
module sampler_lfsr32
    import sampler_pkg::*;
#(
    parameter logic [31:0] SEED_DEF = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    logic [31:0] state_q;

    always_comb begin
        next_o = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
    end

    // An all-zero state would lock up the LFSR, so a zero seed loads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_DEF;
        end else if (load_i) begin
            state_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
        end else if (en_i) begin
            state_q <= next_o;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/constraint_sample_sequencer.sv
// Drives LFSR candidates into a combinational constraint checker and streams passing ones.
// Define SAMPLER_DEDUP_EN to reject a passing candidate equal to the last accepted sample.
module constraint_sample_sequencer
    import sampler_pkg::*;
#(
    parameter int unsigned VEC_W     = 64,
    parameter int unsigned CHK_LAT   = 1,
    parameter int unsigned MAX_TRIES = 1024,
    parameter logic [31:0] SEED_DEF  = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      n_samples_i,
    input  logic             seed_load_i,
    input  logic [31:0]      seed_i,
    output logic [VEC_W-1:0] cand_o,
    input  logic             chk_ok_i,
    output logic             smp_valid_o,
    input  logic             smp_ready_i,
    output logic [VEC_W-1:0] smp_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [15:0]      tries_o,
    output logic [15:0]      accepted_o
);

    localparam int unsigned    NW        = nwords(VEC_W);
    localparam logic [5:0]     LAST_WORD = 6'(NW - 1);
    localparam logic [3:0]     LAST_WAIT = 4'(CHK_LAT - 1);
    localparam logic [CNT_W:0] TRY_LIMIT = (CNT_W + 1)'(MAX_TRIES);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   cand_q, cand_d;
    logic [5:0]         word_q, word_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   tries_q, tries_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_inc;
    logic               timeout_q, timeout_d;
    logic               lfsr_load, lfsr_en;
    logic [31:0]        lfsr_state, lfsr_next;
    logic               dup;

    sampler_lfsr32 #(
        .SEED_DEF(SEED_DEF)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .en_i   (lfsr_en),
        .seed_i (seed_i),
        .state_o(lfsr_state),
        .next_o (lfsr_next)
    );

`ifdef SAMPLER_DEDUP_EN
    logic [VEC_W-1:0] last_q;
    logic             last_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            last_vld_q <= 1'b0;
        end else if (state_q == StEmit && smp_ready_i) begin
            last_q     <= cand_q;
            last_vld_q <= 1'b1;
        end
    end

    assign dup = last_vld_q && (cand_q == last_q);
`else
    assign dup = 1'b0;
`endif

    assign acc_inc = acc_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        word_d    = word_q;
        wcnt_d    = wcnt_q;
        n_d       = n_q;
        tries_d   = tries_q;
        acc_d     = acc_q;
        timeout_d = timeout_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        case (state_q)
            StIdle: begin
                lfsr_load = seed_load_i;
                if (start) begin
                    n_d       = n_samples_i;
                    acc_d     = '0;
                    tries_d   = '0;
                    timeout_d = 1'b0;
                    word_d    = '0;
                    state_d   = (n_samples_i == 16'd0) ? StDone : StGen;
                end
            end
            StGen: begin
                lfsr_en = 1'b1;
                // Older words move up; the top word loses its MSBs when VEC_W%32 != 0.
                cand_d  = VEC_W'({cand_q, lfsr_next});
                if (word_q == LAST_WORD) begin
                    word_d  = '0;
                    wcnt_d  = '0;
                    tries_d = (tries_q == 16'hFFFF) ? tries_q : tries_q + 16'd1;
                    state_d = StWait;
                end else begin
                    word_d = word_q + 6'd1;
                end
            end
            StWait: begin
                if (wcnt_q == LAST_WAIT) begin
                    if (chk_ok_i && !dup) begin
                        state_d = StEmit;
                    end else if ({1'b0, tries_q} >= TRY_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StGen;
                    end
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            StEmit: begin
                if (smp_ready_i) begin
                    acc_d   = acc_inc;
                    tries_d = '0;
                    state_d = (acc_inc == n_q) ? StDone : StGen;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cand_q    <= '0;
            word_q    <= '0;
            wcnt_q    <= '0;
            n_q       <= '0;
            tries_q   <= '0;
            acc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            word_q    <= word_d;
            wcnt_q    <= wcnt_d;
            n_q       <= n_d;
            tries_q   <= tries_d;
            acc_q     <= acc_d;
            timeout_q <= timeout_d;
        end
    end

    assign cand_o      = cand_q;
    assign smp_valid_o = (state_q == StEmit);
    assign smp_data_o  = smp_valid_o ? cand_q : '0;
    assign busy_o      = (state_q == StGen) || (state_q == StWait) || (state_q == StEmit);
    assign done_o      = (state_q == StDone);
    assign timeout_o   = timeout_q;
    assign tries_o     = tries_q;
    assign accepted_o  = acc_q;

endmodule
